// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared types and constants for the data-port responder.
//   st_size_t    - store size carried on d_we
//   uart_state_t - transmitter FSM states
//   *_ADDR       - peripheral register addresses
//   lane_mask()  - byte-enable mask for a store of a given size and offset
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_B    = 2'b01,
        ST_H    = 2'b10,
        ST_W    = 2'b11
    } st_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;
    localparam logic [31:0] TIMER_ADDR     = 32'h1000_0008;

    function automatic logic [3:0] lane_mask(st_size_t size, logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            ST_B:    mask = 4'b0001 << offset;
            ST_H:    mask = offset[1] ? 4'b1100 : 4'b0011;
            ST_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_bus_if.sv
// data_bus_if: core data port.
//   d_we      - store size (st_size_t encoding), 0 = no store
//   d_addr    - byte address
//   d_wr_data - store data, right-justified
//   d_rd_data - registered, word-aligned read data (one cycle after d_addr)
// master = core side, slave = responder side.
interface data_bus_if;
    logic [1:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;

    modport master (
        output d_we,
        output d_addr,
        output d_wr_data,
        input  d_rd_data
    );

    modport slave (
        input  d_we,
        input  d_addr,
        input  d_wr_data,
        output d_rd_data
    );
endinterface

// File: rtl/data_bus_uart_tx.sv
// uart_tx: 8N1 transmit-only UART with a small byte FIFO, LSB first.
//   clk, rst - clock, synchronous active-high reset
//   wr_en    - enqueue wr_data (dropped when full)
//   wr_data  - byte to enqueue
//   full     - FIFO holds FIFO_DEPTH bytes (evaluated before this cycle's pop)
//   empty    - FIFO holds no bytes
//   busy     - FSM is not idle
//   tx       - serial line, idle high
// FIFO_DEPTH must be a power of two >= 2; CLK_DIV >= 2 cycles per bit.
module uart_tx
    import data_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CLK_DIV    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BW = $clog2(CLK_DIV);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push, pop;

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_end;

    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = wr_en && !full;
    assign busy     = (state_q != IDLE);
    assign baud_end = (baud_q == BW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo FIFO_DEPTH; count separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_bus.sv
// data_bus: memory-mapped responder on the core data port.
//   clk, rst - clock, synchronous active-high reset
//   bus      - data port (slave side): d_we, d_addr, d_wr_data in; d_rd_data out
//   uart_tx  - UART serial output, idle high
// Map: RAM at 0 .. RAM_WORDS*4-1, UART_DATA, UART_STAT, TIMER; all else reads 0.
// d_rd_data is the word at the address of the previous cycle (read-before-write).
module data_bus
    import data_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CLK_DIV    = 16
) (
    input  logic      clk,
    input  logic      rst,
    data_bus_if.slave bus,
    output logic      uart_tx
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    st_size_t      size;
    logic [AW-1:0] ram_idx;
    logic          sel_ram, sel_uart_data, sel_uart_stat, sel_timer;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   ram_rd_q;
    logic          sel_ram_q;
    logic [31:0]   periph_rd_d, periph_rd_q;
    logic [31:0]   timer_d, timer_q;
    logic          ovf_d, ovf_q;

    logic          uart_wr, fifo_full, fifo_empty, uart_busy;

    assign size          = st_size_t'(bus.d_we);
    assign ram_idx       = bus.d_addr[AW+1:2];
    assign sel_ram       = (bus.d_addr[31:AW+2] == '0);
    assign sel_uart_data = (bus.d_addr[31:2] == UART_DATA_ADDR[31:2]);
    assign sel_uart_stat = (bus.d_addr[31:2] == UART_STAT_ADDR[31:2]);
    assign sel_timer     = (bus.d_addr[31:2] == TIMER_ADDR[31:2]);

    // Replicate store data across lanes; the byte enables pick the destination.
    always_comb begin
        ram_be    = sel_ram ? lane_mask(size, bus.d_addr[1:0]) : 4'b0000;
        ram_wdata = bus.d_wr_data;
        case (size)
            ST_B:    ram_wdata = {4{bus.d_wr_data[7:0]}};
            ST_H:    ram_wdata = {2{bus.d_wr_data[15:0]}};
            default: ram_wdata = bus.d_wr_data;
        endcase
    end

    always_ff @(posedge clk) begin
        ram_rd_q <= ram[ram_idx];
        for (int i = 0; i < 4; i++) begin
            if (ram_be[i]) begin
                ram[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    assign uart_wr = sel_uart_data && (size != ST_NONE);

    always_comb begin
        periph_rd_d = 32'h0;
        if (sel_uart_stat) begin
            periph_rd_d = {28'h0, ovf_q, uart_busy, fifo_full, fifo_empty};
        end else if (sel_timer) begin
            periph_rd_d = timer_q;
        end
    end

    // The load edge also counts, so a read the cycle after a store sees value + 1.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (sel_timer && size == ST_W) begin
            timer_d = bus.d_wr_data + 32'd1;
        end
    end

    // A STAT access clears ovf after it has been sampled into periph_rd_d.
    always_comb begin
        ovf_d = ovf_q;
        if (uart_wr && fifo_full) begin
            ovf_d = 1'b1;
        end else if (sel_uart_stat) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ram_q   <= 1'b0;
            periph_rd_q <= 32'h0;
            timer_q     <= 32'h0;
            ovf_q       <= 1'b0;
        end else begin
            sel_ram_q   <= sel_ram;
            periph_rd_q <= periph_rd_d;
            timer_q     <= timer_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.d_rd_data = sel_ram_q ? ram_rd_q : periph_rd_q;

    uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (uart_wr),
        .wr_data (bus.d_wr_data[7:0]),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .busy    (uart_busy),
        .tx      (uart_tx)
    );

endmodule

// File: tb/tb_data_bus.sv
module tb_data_bus;
    import data_bus_pkg::*;

    localparam int unsigned TB_CLK_DIV = 4;
    localparam int unsigned TB_FIFO    = 8;

    typedef struct {
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          check;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;
    int   checks = 0;
    int   errors = 0;
    bit   rx_en  = 1'b0;
    logic [7:0] rx_q [$];

    data_bus_if bus ();

    data_bus #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (TB_FIFO),
        .CLK_DIV    (TB_CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; the store is withdrawn after the edge so waits are pure reads.
    task automatic drive(input logic [1:0] we, input logic [31:0] addr, input logic [31:0] wd);
        bus.d_we      = we;
        bus.d_addr    = addr;
        bus.d_wr_data = wd;
        @(posedge clk);
        #1;
        bus.d_we = ST_NONE;
    endtask

    // Independent 8N1 receiver sampling mid-bit on the falling clock edge.
    initial begin : rx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && uart_tx === 1'b0) begin
                repeat (TB_CLK_DIV / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (TB_CLK_DIV) @(negedge clk);
                    b[k] = uart_tx;
                end
                repeat (TB_CLK_DIV) @(negedge clk);
                chk("rx_stop_bit", {31'h0, uart_tx}, 32'h1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t       vecs [23];
        logic [9:0] pat;
        int         lows;

        vecs[0]  = '{ST_W,    32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{ST_B,    32'h0000_0012, 32'h0000_005A, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{ST_NONE, 32'h0000_0010, 32'h0,         1'b1, 32'hDE5A_BEEF};
        vecs[3]  = '{ST_W,    32'h0000_0020, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{ST_H,    32'h0000_0022, 32'h0000_1234, 1'b1, 32'h0000_0000};
        vecs[5]  = '{ST_NONE, 32'h0000_0020, 32'h0,         1'b1, 32'h1234_0000};
        vecs[6]  = '{ST_H,    32'h0000_0021, 32'h0000_ABCD, 1'b1, 32'h1234_0000};
        vecs[7]  = '{ST_NONE, 32'h0000_0020, 32'h0,         1'b1, 32'h1234_ABCD};
        vecs[8]  = '{ST_W,    32'h0000_0024, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9]  = '{ST_H,    32'h0000_0024, 32'hFFFF_5678, 1'b1, 32'hCAFE_F00D};
        vecs[10] = '{ST_NONE, 32'h0000_0024, 32'h0,         1'b1, 32'hCAFE_5678};
        vecs[11] = '{ST_B,    32'h0000_0027, 32'h0000_01FF, 1'b1, 32'hCAFE_5678};
        vecs[12] = '{ST_NONE, 32'h0000_0024, 32'h0,         1'b1, 32'hFFFE_5678};
        vecs[13] = '{ST_W,    32'h0000_0003, 32'h1122_3344, 1'b0, 32'h0};
        vecs[14] = '{ST_NONE, 32'h0000_0000, 32'h0,         1'b1, 32'h1122_3344};
        vecs[15] = '{ST_W,    32'h0000_1000, 32'h0000_0099, 1'b1, 32'h0};
        vecs[16] = '{ST_NONE, 32'h0000_0000, 32'h0,         1'b1, 32'h1122_3344};
        vecs[17] = '{ST_W,    32'h0000_0FFC, 32'h0000_0077, 1'b0, 32'h0};
        vecs[18] = '{ST_NONE, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0000_0077};
        vecs[19] = '{ST_W,    32'h2000_0000, 32'h0000_0055, 1'b1, 32'h0};
        vecs[20] = '{ST_NONE, UART_DATA_ADDR, 32'h0,        1'b1, 32'h0};
        vecs[21] = '{ST_W,    UART_STAT_ADDR, 32'hFFFF_FFFF, 1'b1, 32'h1};
        vecs[22] = '{ST_NONE, UART_STAT_ADDR, 32'h0,        1'b1, 32'h1};

        // Reset state
        rst           = 1'b1;
        bus.d_we      = ST_NONE;
        bus.d_addr    = 32'h0;
        bus.d_wr_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_data", bus.d_rd_data, 32'h0);
        chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        bus.d_addr = TIMER_ADDR;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        chk("timer_reset", bus.d_rd_data, 32'h0);
        @(posedge clk);
        #1;
        chk("timer_first_inc", bus.d_rd_data, 32'h1);

        // Table-driven RAM / decode vectors
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd);
            if (vecs[i].check) chk($sformatf("vec%0d", i), bus.d_rd_data, vecs[i].exp);
        end

        // Timer load, wrap, and ignored sub-word stores
        drive(ST_W, TIMER_ADDR, 32'hFFFF_FFFE);
        drive(ST_NONE, TIMER_ADDR, 32'h0);
        chk("timer_after_load", bus.d_rd_data, 32'hFFFF_FFFF);
        drive(ST_NONE, TIMER_ADDR, 32'h0);
        chk("timer_wrap", bus.d_rd_data, 32'h0);
        drive(ST_NONE, TIMER_ADDR, 32'h0);
        chk("timer_post_wrap", bus.d_rd_data, 32'h1);
        drive(ST_H, TIMER_ADDR, 32'h0);
        chk("timer_h_store_cycle", bus.d_rd_data, 32'h2);
        drive(ST_B, TIMER_ADDR, 32'h0);
        chk("timer_h_ignored", bus.d_rd_data, 32'h3);
        drive(ST_NONE, TIMER_ADDR, 32'h0);
        chk("timer_b_ignored", bus.d_rd_data, 32'h4);

        // Single frame 0x41
        pat = {1'b1, 8'h41, 1'b0};
        drive(ST_B, UART_DATA_ADDR, 32'h0000_0041);
        bus.d_addr = UART_STAT_ADDR;
        chk("tx_before_start", {31'h0, uart_tx}, 32'h1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tx_bit%0d_c%0d", i / 4, i % 4), {31'h0, uart_tx}, {31'h0, pat[i/4]});
            if (i == 20) chk("stat_busy_midframe", bus.d_rd_data, 32'h5);
        end
        @(posedge clk);
        #1;
        chk("tx_idle_after_frame", {31'h0, uart_tx}, 32'h1);
        drive(ST_NONE, UART_STAT_ADDR, 32'h0);
        chk("stat_idle_after_frame", bus.d_rd_data, 32'h1);

        // FIFO fill: 9 accepted, 10th dropped
        rx_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(ST_B, UART_DATA_ADDR, 32'hA0 + i);
        end
        drive(ST_NONE, UART_STAT_ADDR, 32'h0);
        chk("stat_overflow", bus.d_rd_data, 32'hE);
        drive(ST_NONE, UART_STAT_ADDR, 32'h0);
        chk("stat_ovf_cleared", bus.d_rd_data, 32'h6);
        bus.d_addr = 32'h0;
        for (int c = 0; c < 600 && rx_q.size() < 9; c++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        chk("rx_byte_count", rx_q.size(), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            chk($sformatf("rx_byte%0d", i), {24'h0, rx_q[i]}, 32'hA0 + i);
        end
        rx_en = 1'b0;
        drive(ST_NONE, UART_STAT_ADDR, 32'h0);
        chk("stat_after_burst", bus.d_rd_data, 32'h1);

        // Reset 15 cycles into a frame with one byte still queued
        drive(ST_B, UART_DATA_ADDR, 32'h0);
        drive(ST_B, UART_DATA_ADDR, 32'h0);
        bus.d_addr = 32'h0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        chk("tx_low_midframe", {31'h0, uart_tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("tx_high_on_reset", {31'h0, uart_tx}, 32'h1);
        chk("rd_data_on_reset", bus.d_rd_data, 32'h0);
        rst = 1'b0;
        drive(ST_NONE, UART_STAT_ADDR, 32'h0);
        chk("stat_after_reset", bus.d_rd_data, 32'h1);
        drive(ST_NONE, 32'h2000_0000, 32'h0);
        chk("unmapped_read", bus.d_rd_data, 32'h0);
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) lows++;
        end
        chk("fifo_discarded", lows, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
